// File: rtl/tx_reset_sequencer_if.sv
// TX reset sequencer signal bundle: switch request, TX idle status, TX reset
// and sequencer status. master = sequencer side, slave = system/TX side.
interface tx_reset_sequencer_if;
    logic       sw_stat;
    logic       tx_idle;
    logic       tx_resetn;
    logic       busy;
    logic       rst_done;
    logic       drain_to;
    logic [7:0] rst_count;

    modport master (
        input  sw_stat,
        input  tx_idle,
        output tx_resetn,
        output busy,
        output rst_done,
        output drain_to,
        output rst_count
    );

    modport slave (
        output sw_stat,
        output tx_idle,
        input  tx_resetn,
        input  busy,
        input  rst_done,
        input  drain_to,
        input  rst_count
    );
endinterface

// File: rtl/tx_reset_sequencer.sv
// TX reset sequencer: a rising edge on sw_stat drains the TX path (or times
// out), holds tx_resetn low, then waits a recovery period before re-arming.
// Ports: aclk, aresetn (async, active-low), bus (tx_reset_sequencer_if.master):
//   sw_stat, tx_idle in; tx_resetn, busy, rst_done, drain_to, rst_count out.
// Optional macro TX_RST_COUNTER_EN enables the saturating rst_count register;
// without it rst_count is tied to zero.
module tx_reset_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int DRAIN_TIMEOUT  = 200
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    tx_reset_sequencer_if.master   bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_ASSERT  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] timer;
    logic       sw_stat_d;
    logic       req;
    logic       done_nxt;
    logic       drain_expire;
    logic       tx_resetn_q;
    logic       busy_q;
    logic       done_q;
    logic       drain_q;

    always_comb begin
        req          = bus.sw_stat & ~sw_stat_d;
        drain_expire = (state == S_DRAIN) && !bus.tx_idle
                       && (timer == DRAIN_LAST);
        state_nxt    = state;
        case (state)
            S_IDLE:    if (req) state_nxt = S_DRAIN;
            S_DRAIN:   if (bus.tx_idle || timer == DRAIN_LAST)
                           state_nxt = S_ASSERT;
            S_ASSERT:  if (timer == RST_LAST) state_nxt = S_RECOVER;
            S_RECOVER: if (timer == HOLD_LAST) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        done_nxt = (state == S_RECOVER) && (state_nxt == S_IDLE);
    end

    // Outputs are registered from the next state so they line up with it.
    // sw_stat_d resets high so a switch already on at release is not a request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            timer       <= 8'd0;
            sw_stat_d   <= 1'b1;
            tx_resetn_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= (state_nxt != state) ? 8'd0 : timer + 8'd1;
            sw_stat_d   <= bus.sw_stat;
            tx_resetn_q <= (state_nxt != S_ASSERT);
            busy_q      <= (state_nxt != S_IDLE);
            done_q      <= done_nxt;
            if (drain_expire)
                drain_q <= 1'b1;
        end
    end

`ifdef TX_RST_COUNTER_EN
    logic [7:0] cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            cnt_q <= 8'd0;
        else if (done_nxt && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
    end

    assign bus.rst_count = cnt_q;
`else
    assign bus.rst_count = 8'd0;
`endif

    assign bus.tx_resetn = tx_resetn_q;
    assign bus.busy      = busy_q;
    assign bus.rst_done  = done_q;
    assign bus.drain_to  = drain_q;
endmodule

// File: tb/tb_tx_reset_sequencer.sv
// Directed testbench for tx_reset_sequencer (default parameters).
// Works with or without TX_RST_COUNTER_EN defined.
module tb_tx_reset_sequencer;
    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    tx_reset_sequencer_if bus ();

    tx_reset_sequencer dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_req   = 0;

    int first_low, last_low, n_low;
    int first_busy, last_busy, n_busy;
    int done_at, n_done;
    int cnt_exp;

    always @(posedge aclk) cyc <= cyc + 1;

    // Per-cycle record of outputs, relative to the request cycle.
    always @(negedge aclk) begin
        int rel;
        rel = cyc - t_req;
        if (!bus.tx_resetn) begin
            if (first_low < 0) first_low = rel;
            last_low = rel;
            n_low++;
        end
        if (bus.busy) begin
            if (first_busy < 0) first_busy = rel;
            last_busy = rel;
            n_busy++;
        end
        if (bus.rst_done) begin
            done_at = rel;
            n_done++;
        end
    end

    function automatic int exp_cnt(input int n);
`ifdef TX_RST_COUNTER_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon;
        first_low  = -1; last_low  = -1; n_low  = 0;
        first_busy = -1; last_busy = -1; n_busy = 0;
        done_at    = -1; n_done    = 0;
    endtask

    task automatic request;
        bus.sw_stat = 1'b1;
        t_req = cyc;
        clear_mon();
    endtask

    task automatic wait_done;
        int k;
        for (k = 0; k < 300; k++) begin
            step(1);
            if (bus.rst_done) break;
        end
        if (k == 300) chk("done_timeout", 0, 1);
    endtask

    initial begin
        clear_mon();
        bus.sw_stat = 1'b0;
        bus.tx_idle = 1'b1;

        // Reset values, applied asynchronously
        #2 aresetn = 1'b0;
        #1;
        chk("rst_tx_resetn", int'(bus.tx_resetn), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.rst_done), 0);
        chk("rst_drain_to", int'(bus.drain_to), 0);
        chk("rst_count", int'(bus.rst_count), 0);
        step(2);
        chk("rst_hold_txr", int'(bus.tx_resetn), 0);
        aresetn = 1'b1;
        step(1);
        chk("rel_txr", int'(bus.tx_resetn), 1);

        // Nominal sequence, extra rising edge during ASSERT ignored
        step(2);
        request();
        step(5);
        bus.sw_stat = 1'b0;
        step(2);
        bus.sw_stat = 1'b1;
        step(95);
        chk("nom_first_low", first_low, 2);
        chk("nom_last_low", last_low, 17);
        chk("nom_n_low", n_low, 16);
        chk("nom_first_busy", first_busy, 1);
        chk("nom_last_busy", last_busy, 81);
        chk("nom_n_busy", n_busy, 81);
        chk("nom_done_at", done_at, 82);
        chk("nom_n_done", n_done, 1);
        chk("nom_count", int'(bus.rst_count), exp_cnt(1));
        chk("nom_drain_to", int'(bus.drain_to), 0);

        // Drain timeout with tx_idle low
        bus.sw_stat = 1'b0;
        bus.tx_idle = 1'b0;
        step(2);
        request();
        step(300);
        chk("to_first_low", first_low, 201);
        chk("to_last_low", last_low, 216);
        chk("to_n_low", n_low, 16);
        chk("to_done_at", done_at, 281);
        chk("to_drain_to", int'(bus.drain_to), 1);
        chk("to_count", int'(bus.rst_count), exp_cnt(2));

        // Normal drain afterwards leaves drain_to set
        bus.sw_stat = 1'b0;
        bus.tx_idle = 1'b1;
        step(2);
        request();
        step(100);
        chk("sticky_first_low", first_low, 2);
        chk("sticky_drain_to", int'(bus.drain_to), 1);
        chk("sticky_count", int'(bus.rst_count), exp_cnt(3));

        // Switch held high across reset release: no sequence
        bus.sw_stat = 1'b1;
        aresetn = 1'b0;
        step(2);
        aresetn = 1'b1;
        t_req = cyc;
        clear_mon();
        step(1);
        chk("hold_txr", int'(bus.tx_resetn), 1);
        step(30);
        chk("hold_n_busy", n_busy, 0);
        chk("hold_n_done", n_done, 0);
        chk("hold_count", int'(bus.rst_count), 0);
        chk("hold_drain_to", int'(bus.drain_to), 0);

        // Reset during RECOVER aborts without completion
        bus.sw_stat = 1'b0;
        step(2);
        request();
        step(40);
        #2 aresetn = 1'b0;
        #1;
        chk("ab_txr", int'(bus.tx_resetn), 0);
        chk("ab_busy", int'(bus.busy), 0);
        chk("ab_done", int'(bus.rst_done), 0);
        chk("ab_count", int'(bus.rst_count), 0);
        step(2);
        aresetn = 1'b1;
        step(100);
        chk("ab_n_done", n_done, 0);
        chk("ab_count2", int'(bus.rst_count), 0);
        bus.sw_stat = 1'b0;
        step(2);
        request();
        step(100);
        chk("ab_re_low", first_low, 2);
        chk("ab_re_n_done", n_done, 1);
        chk("ab_re_done_at", done_at, 82);
        chk("ab_re_count", int'(bus.rst_count), exp_cnt(1));

        // Back-to-back sequences: saturation
        cnt_exp = 1;
        for (int i = 0; i < 300; i++) begin
            bus.sw_stat = 1'b0;
            step(1);
            request();
            wait_done();
            cnt_exp++;
            chk("b2b_count", int'(bus.rst_count), exp_cnt(cnt_exp));
        end
        step(3);
        chk("b2b_final", int'(bus.rst_count), exp_cnt(301));
        chk("b2b_busy", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
